// File: rtl/bcd_serial_adder_if.sv
// Handshake bundle for the digit-serial BCD adder.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface bcd_serial_adder_if #(
  parameter int NDIG = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] a;
  logic [4*NDIG-1:0] b;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] sum;
  logic              cout;
  logic              err;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, least significant digit first.
// Single transaction in flight, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding digit r_idx, carry held in r_carry
// DONE  | result held, out_valid high until out_ready
module bcd_serial_adder #(
  parameter int NDIG = 4
) (
  input logic               clk,
  input logic               rst_n,
  bcd_serial_adder_if.slave bus
);
  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_err;

  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [4:0]      w_s;
  logic            w_carry;
  logic [3:0]      w_dig;
  logic            w_bad;
  logic            w_last;

  // Operands shift right each digit, so the current digit is always in the low nibble.
  assign w_a_dig = r_a[3:0];
  assign w_b_dig = r_b[3:0];
  assign w_s     = 5'(w_a_dig) + 5'(w_b_dig) + 5'(r_carry);
  assign w_carry = (w_s > 5'd9);
  assign w_dig   = w_carry ? (w_s[3:0] + 4'd6) : w_s[3:0];
  assign w_bad   = (w_a_dig > 4'd9) | (w_b_dig > 4'd9);
  assign w_last  = (r_idx == IW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_dig;
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_carry;
          r_err   <= r_err | w_bad;
          if (w_last) begin
            r_cout  <= w_carry;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: expected results queued at acceptance,
// popped by an independent monitor on each output handshake.
module tb_bcd_serial_adder;
  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  exp_t mon_e;

  bcd_serial_adder_if #(.NDIG(NDIG)) ifc ();

  bcd_serial_adder #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Decimal arithmetic when every digit is legal; otherwise the per-digit rule.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t r;
    int   va, vb, tot, m, s, cy;
    bit   ok;
    r  = '0;
    va = 0; vb = 0; m = 1; ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) ok = 1'b0;
      va += int'(a[4*i +: 4]) * m;
      vb += int'(b[4*i +: 4]) * m;
      m  *= 10;
    end
    r.err = !ok;
    if (ok) begin
      tot    = va + vb + int'(c);
      r.cout = (tot >= m);
      tot    = tot % m;
      for (int i = 0; i < NDIG; i++) begin
        r.sum[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      cy = int'(c);
      for (int i = 0; i < NDIG; i++) begin
        s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + cy;
        if (s > 9) begin
          r.sum[4*i +: 4] = 4'((s + 6) % 16);
          cy = 1;
        end else begin
          r.sum[4*i +: 4] = 4'(s);
          cy = 0;
        end
      end
      r.cout = (cy != 0);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Monitor: compares on every output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got sum 0x%0h with empty scoreboard", ifc.sum);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sum",  32'(ifc.sum),  32'(mon_e.sum));
          chk("cout", 32'(ifc.cout), 32'(mon_e.cout));
          chk("err",  32'(ifc.err),  32'(mon_e.err));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int hold, input bit sim_in);
    int   n;
    exp_t e;
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", 32'(ifc.in_ready), 32'd1);
    ifc.a = ta; ifc.b = tb; ifc.cin = tc; ifc.in_valid = 1'b1; ifc.out_ready = 1'b0;
    @(posedge clk); #1;
    e = model(ta, tb, tc);
    exp_q.push_back(e);
    ifc.in_valid = 1'b0;
    ifc.a = W'($urandom); ifc.b = W'($urandom); ifc.cin = 1'($urandom);
    n = 0;
    while (!ifc.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(NDIG));
    for (int i = 0; i < hold; i++) begin
      chk("hold_sum",      32'(ifc.sum),       32'(e.sum));
      chk("hold_in_ready", 32'(ifc.in_ready),  32'd0);
      chk("hold_valid",    32'(ifc.out_valid), 32'd1);
      ifc.in_valid = (i == 1);
      @(posedge clk); #1;
    end
    ifc.in_valid  = sim_in;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b0;
    chk("in_ready_after_out", 32'(ifc.in_ready),  32'd1);
    chk("out_valid_dropped",  32'(ifc.out_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_sum",       32'(ifc.sum),       32'd0);
    chk("rst_cout",      32'(ifc.cout),      32'd0);
    chk("rst_err",       32'(ifc.err),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

    do_txn(16'h0009, 16'h0003, 1'b0, 0, 1'b0);
    do_txn(16'h9999, 16'h0001, 1'b0, 0, 1'b0);
    do_txn(16'h0000, 16'h0000, 1'b1, 1, 1'b0);
    do_txn(16'h4567, 16'h5432, 1'b1, 0, 1'b0);
    do_txn(16'h1234, 16'h4321, 1'b0, 5, 1'b1);
    do_txn(16'h000A, 16'h0000, 1'b0, 0, 1'b0);
    chk("err_held_after_out", 32'(ifc.err), 32'd1);
    chk("sum_held_after_out", 32'(ifc.sum), 32'h0010);
    do_txn(16'h0021, 16'h0078, 1'b0, 0, 1'b0);
    chk("err_cleared", 32'(ifc.err), 32'd0);

    // Reset during the second RUN cycle aborts the transaction.
    ifc.a = 16'h9999; ifc.b = 16'h9999; ifc.cin = 1'b0; ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_sum",       32'(ifc.sum),       32'd0);
    chk("midrst_cout",      32'(ifc.cout),      32'd0);
    chk("midrst_err",       32'(ifc.err),       32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;
    do_txn(16'h0009, 16'h0003, 1'b0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic [W-1:0] ra, rb;
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 3) == 0) ra[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom);
      if ($urandom_range(0, 5) == 0) rb = W'($urandom);
      do_txn(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
